// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, operand-B source codes and sequencer FSM encoding.
package mips_pkg;
    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_CNT  = 16;

    localparam logic [1:0] BSEL_REG     = 2'b00;
    localparam logic [1:0] BSEL_IMM     = 2'b01;
    localparam logic [1:0] BSEL_FWD_MEM = 2'b10;
    localparam logic [1:0] BSEL_FWD_WB  = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;
endpackage

// File: rtl/rt_hazard_detect.sv
// rt_hazard_detect: per-stage rt match flags and the load-use flag for operand B.
module rt_hazard_detect
    import mips_pkg::*;
#(
    parameter int NB_REG = mips_pkg::NB_REG
) (
    input  logic              i_valid,
    input  logic              i_uses_rt,
    input  logic [NB_REG-1:0] i_rt,
    input  logic              i_ex_memread,
    input  logic              i_ex_regwrite,
    input  logic [NB_REG-1:0] i_ex_rd,
    input  logic              i_mem_regwrite,
    input  logic [NB_REG-1:0] i_mem_rd,
    input  logic              i_wb_regwrite,
    input  logic [NB_REG-1:0] i_wb_rd,
    output logic              o_ex_match,
    output logic              o_mem_match,
    output logic              o_wb_match,
    output logic              o_load_use
);
    logic reads_rt;

    // r0 is hardwired to zero, so it never carries a dependency
    assign reads_rt    = i_valid && i_uses_rt && (i_rt != '0);
    assign o_ex_match  = reads_rt && i_ex_regwrite && (i_ex_rd == i_rt);
    assign o_mem_match = reads_rt && i_mem_regwrite && (i_mem_rd == i_rt);
    assign o_wb_match  = reads_rt && i_wb_regwrite && (i_wb_rd == i_rt);
    assign o_load_use  = o_ex_match && i_ex_memread;
endmodule

// File: rtl/operand_b_sequencer.sv
// operand_b_sequencer: ID/EX operand-B select, rt hazard stall and bubble insertion.
// Define OPB_FORWARDING_EN to forward from MEM/WB; otherwise every match stalls.
module operand_b_sequencer
    import mips_pkg::*;
#(
    parameter int NB_DATA = mips_pkg::NB_DATA,
    parameter int NB_REG  = mips_pkg::NB_REG,
    parameter int NB_CNT  = mips_pkg::NB_CNT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic               i_tipeI,
    input  logic               i_uses_rt,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_DATA-1:0] i_inmediate,
    input  logic [NB_DATA-1:0] i_dataB,
    input  logic               i_ex_memread,
    input  logic               i_ex_regwrite,
    input  logic [NB_REG-1:0]  i_ex_rd,
    input  logic               i_mem_regwrite,
    input  logic [NB_REG-1:0]  i_mem_rd,
    input  logic [NB_DATA-1:0] i_mem_result,
    input  logic               i_wb_regwrite,
    input  logic [NB_REG-1:0]  i_wb_rd,
    input  logic [NB_DATA-1:0] i_wb_result,
    output logic [NB_DATA-1:0] o_B_to_alu,
    output logic [1:0]         o_bsel,
    output logic               o_valid,
    output logic               o_stall,
    output logic [NB_CNT-1:0]  o_stall_count
);
    state_t             state, next_state;
    logic               ex_match, mem_match, wb_match, load_use, hazard;
    logic [1:0]         sel;
    logic [NB_DATA-1:0] operand;

    rt_hazard_detect #(.NB_REG(NB_REG)) u_rt_hazard_detect (
        .i_valid        (i_valid),
        .i_uses_rt      (i_uses_rt),
        .i_rt           (i_rt),
        .i_ex_memread   (i_ex_memread),
        .i_ex_regwrite  (i_ex_regwrite),
        .i_ex_rd        (i_ex_rd),
        .i_mem_regwrite (i_mem_regwrite),
        .i_mem_rd       (i_mem_rd),
        .i_wb_regwrite  (i_wb_regwrite),
        .i_wb_rd        (i_wb_rd),
        .o_ex_match     (ex_match),
        .o_mem_match    (mem_match),
        .o_wb_match     (wb_match),
        .o_load_use     (load_use)
    );

`ifdef OPB_FORWARDING_EN
    logic unused_fwd;
    assign unused_fwd = ex_match;
    assign hazard = !i_tipeI && load_use;
    // MEM beats WB because it holds the younger write to rt
    assign sel = !i_valid   ? BSEL_REG :
                 i_tipeI    ? BSEL_IMM :
                 mem_match  ? BSEL_FWD_MEM :
                 wb_match   ? BSEL_FWD_WB : BSEL_REG;
`else
    logic unused_nofwd;
    assign unused_nofwd = load_use;
    // without bypass paths, wait until the producer has written the register file
    assign hazard = !i_tipeI && (ex_match || mem_match || wb_match);
    assign sel = (i_valid && i_tipeI) ? BSEL_IMM : BSEL_REG;
`endif

    assign o_stall = hazard;

    always_comb begin
        operand    = (sel == BSEL_IMM)     ? i_inmediate :
                     (sel == BSEL_FWD_MEM) ? i_mem_result :
                     (sel == BSEL_FWD_WB)  ? i_wb_result : i_dataB;
        next_state = !i_enable ? state : (hazard ? STALL : RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            o_B_to_alu    <= '0;
            o_bsel        <= BSEL_REG;
            o_valid       <= 1'b0;
            o_stall_count <= '0;
        end else if (i_enable) begin
            state         <= next_state;
            o_B_to_alu    <= (next_state == STALL) ? '0 : operand;
            o_bsel        <= (next_state == STALL) ? BSEL_REG : sel;
            o_valid       <= (next_state == RUN) && i_valid;
            if (next_state == STALL && o_stall_count != '1)
                o_stall_count <= o_stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_operand_b_sequencer.sv
// tb_operand_b_sequencer: directed vectors for operand_b_sequencer, both forwarding builds.
module tb_operand_b_sequencer;
    import mips_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_enable, i_valid, i_tipeI, i_uses_rt;
    logic [4:0]  i_rt, i_ex_rd, i_mem_rd, i_wb_rd;
    logic [31:0] i_inmediate, i_dataB, i_mem_result, i_wb_result;
    logic        i_ex_memread, i_ex_regwrite, i_mem_regwrite, i_wb_regwrite;
    logic [31:0] o_B_to_alu;
    logic [1:0]  o_bsel;
    logic        o_valid, o_stall;
    logic [15:0] o_stall_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    operand_b_sequencer dut (
        .clock(clock), .reset(reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_tipeI(i_tipeI), .i_uses_rt(i_uses_rt), .i_rt(i_rt),
        .i_inmediate(i_inmediate), .i_dataB(i_dataB),
        .i_ex_memread(i_ex_memread), .i_ex_regwrite(i_ex_regwrite), .i_ex_rd(i_ex_rd),
        .i_mem_regwrite(i_mem_regwrite), .i_mem_rd(i_mem_rd), .i_mem_result(i_mem_result),
        .i_wb_regwrite(i_wb_regwrite), .i_wb_rd(i_wb_rd), .i_wb_result(i_wb_result),
        .o_B_to_alu(o_B_to_alu), .o_bsel(o_bsel), .o_valid(o_valid),
        .o_stall(o_stall), .o_stall_count(o_stall_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        i_valid = 0; i_tipeI = 0; i_uses_rt = 0; i_rt = 0;
        i_ex_memread = 0; i_ex_regwrite = 0; i_ex_rd = 0;
        i_mem_regwrite = 0; i_mem_rd = 0; i_wb_regwrite = 0; i_wb_rd = 0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] b, input logic [1:0] s, input logic v);
        check({tag, "_b"}, o_B_to_alu, b);
        check({tag, "_bsel"}, {30'd0, o_bsel}, {30'd0, s});
        check({tag, "_valid"}, {31'd0, o_valid}, {31'd0, v});
    endtask

    task automatic chk_stall(input string tag, input logic s);
        #1;
        check({tag, "_stall"}, {31'd0, o_stall}, {31'd0, s});
    endtask

    task automatic chk_bubble(input string tag);
        chk_out(tag, 32'd0, 2'b00, 1'b0);
        exp_cnt++;
        check({tag, "_cnt"}, {16'd0, o_stall_count}, exp_cnt);
    endtask

    task automatic rt_dep(input logic [4:0] r);
        idle();
        i_valid = 1; i_uses_rt = 1; i_rt = r;
    endtask

    initial begin
        idle();
        i_enable = 1; i_dataB = 32'h1234_5678; i_inmediate = 0;
        i_mem_result = 0; i_wb_result = 0;
        #12;
        chk_out("reset", 32'd0, 2'b00, 1'b0);
        check("reset_cnt", {16'd0, o_stall_count}, 0);
        check("reset_stall", {31'd0, o_stall}, 0);
        reset = 1;

        i_valid = 1; i_tipeI = 1; i_inmediate = 32'h10;
        step();
        chk_out("imm", 32'h10, 2'b01, 1'b1);

        i_tipeI = 0; i_uses_rt = 1; i_rt = 0;
        i_ex_regwrite = 1; i_ex_memread = 1; i_mem_regwrite = 1; i_wb_regwrite = 1;
        chk_stall("rt0", 1'b0);
        step();
        chk_out("rt0", 32'h1234_5678, 2'b00, 1'b1);

        rt_dep(5);
        i_mem_regwrite = 1; i_mem_rd = 5; i_mem_result = 32'hAAAA_0001;
        i_wb_regwrite = 1; i_wb_rd = 5; i_wb_result = 32'hBBBB_0002;
`ifdef OPB_FORWARDING_EN
        chk_stall("memwb", 1'b0);
        step();
        chk_out("memwb", 32'hAAAA_0001, 2'b10, 1'b1);
        i_mem_regwrite = 0;
        step();
        chk_out("wbonly", 32'hBBBB_0002, 2'b11, 1'b1);
`else
        chk_stall("memwb", 1'b1);
        step();
        chk_bubble("memwb_b1");
        i_mem_regwrite = 0; i_wb_result = 32'hAAAA_0001;
        chk_stall("memwb_wb", 1'b1);
        step();
        chk_bubble("memwb_b2");
        i_wb_regwrite = 0; i_dataB = 32'hAAAA_0001;
        chk_stall("memwb_clr", 1'b0);
        step();
        chk_out("memwb_reg", 32'hAAAA_0001, 2'b00, 1'b1);
`endif

        rt_dep(7);
        i_ex_regwrite = 1; i_ex_memread = 1; i_ex_rd = 7; i_enable = 0;
        chk_stall("frozen", 1'b1);
        step();
`ifdef OPB_FORWARDING_EN
        chk_out("frozen", 32'hBBBB_0002, 2'b11, 1'b1);
`else
        chk_out("frozen", 32'hAAAA_0001, 2'b00, 1'b1);
`endif
        check("frozen_cnt", {16'd0, o_stall_count}, exp_cnt);
        i_enable = 1;
        step();
        chk_bubble("ld_use");
        i_ex_regwrite = 0; i_ex_memread = 0;
        i_mem_regwrite = 1; i_mem_rd = 7; i_mem_result = 32'h77;
`ifdef OPB_FORWARDING_EN
        chk_stall("ld_mem", 1'b0);
        step();
        chk_out("ld_fwd", 32'h77, 2'b10, 1'b1);
`else
        chk_stall("ld_mem", 1'b1);
        step();
        chk_bubble("ld_b2");
        i_mem_regwrite = 0; i_wb_regwrite = 1; i_wb_rd = 7; i_wb_result = 32'h77;
        step();
        chk_bubble("ld_b3");
        i_wb_regwrite = 0; i_dataB = 32'h77;
        step();
        chk_out("ld_reg", 32'h77, 2'b00, 1'b1);
`endif

        rt_dep(9);
        i_valid = 0; i_tipeI = 1; i_ex_regwrite = 1; i_ex_memread = 1; i_ex_rd = 9;
        chk_stall("inval", 1'b0);
        step();
        check("inval_valid", {31'd0, o_valid}, 0);
        check("inval_bsel", {30'd0, o_bsel}, 0);

        rt_dep(7);
        i_ex_regwrite = 1; i_ex_memread = 1; i_ex_rd = 7;
        step();
        chk_bubble("pre_rst");
        #2 reset = 0;
        #1;
        chk_out("rst_mid", 32'd0, 2'b00, 1'b0);
        check("rst_mid_cnt", {16'd0, o_stall_count}, 0);
        exp_cnt = 0;
        reset = 1;
        idle();
        i_valid = 1; i_tipeI = 1; i_inmediate = 32'h55;
        step();
        chk_out("post_rst", 32'h55, 2'b01, 1'b1);

        rt_dep(3);
        i_ex_regwrite = 1; i_ex_rd = 3; i_dataB = 32'h0;
`ifdef OPB_FORWARDING_EN
        chk_stall("alu_ex", 1'b0);
        step();
        check("alu_ex_cnt", {16'd0, o_stall_count}, 0);
`else
        chk_stall("alu_ex", 1'b1);
        step();
        chk_bubble("alu_b1");
        i_ex_regwrite = 0; i_mem_regwrite = 1; i_mem_rd = 3;
        step();
        chk_bubble("alu_b2");
        i_mem_regwrite = 0; i_wb_regwrite = 1; i_wb_rd = 3;
        step();
        chk_bubble("alu_b3");
        i_wb_regwrite = 0; i_dataB = 32'h33;
        chk_stall("alu_clr", 1'b0);
        step();
        chk_out("alu_reg", 32'h33, 2'b00, 1'b1);
        check("alu_cnt", {16'd0, o_stall_count}, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
